rsbus_devnull_q: RTL

- Parametrised ring-bus sink and responder.
- Removes matching frames from the d2r ring and discards write payloads.
- Queues up to RSP_DEPTH read/update responses and inserts each into the next empty r2d slot of matching length, oldest first.
- Intended as a terminator for unmapped address windows, or as a memory stub in ring-bus test systems.

---
 rtl/rsbus_devnull_q.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/rsbus_devnull_q.sv
// rsbus_devnull_q: ring-bus sink and responder.
// Takes matching frames off the d2r ring, discards write payloads, and queues
// read/update response headers. Each queued header goes into the next empty
// r2d slot of matching length, with the payload made from FILL_DWORD.
//
// Word layout (70 bits), header view:
//   [69] frm_used  [68] frm_owned  [67:66] frm_priority  [65] frm_len
//   [64:62] mem_op [61:60] mem_space [59:52] net_addr [51:48] frm_sid
//   [47:40] frm_rid [39:0] mem_addr
// Payload words are {6-bit tag, 64-bit data}.
// Control word (4 bits): [3] valid, [2:0] side information.
module rsbus_devnull_q #(
    parameter int unsigned RSP_DEPTH  = 4,
    parameter logic [39:0] ADDR_BASE  = '0,
    parameter logic [39:0] ADDR_MASK  = '0,
    parameter logic [63:0] FILL_DWORD = 64'hABBA_FACE_CAFE_BACA,
    parameter int unsigned FILL_MODE  = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         d2r_i_sof,
    input  logic [3:0]                   d2r_i_ctrl,
    input  logic [69:0]                  d2r_i_bus,
    output logic                         d2r_o_sof,
    output logic [3:0]                   d2r_o_ctrl,
    output logic [69:0]                  d2r_o_bus,
    input  logic                         r2d_i_sof,
    input  logic [69:0]                  r2d_i_bus,
    output logic                         r2d_o_sof,
    output logic [69:0]                  r2d_o_bus,
    output logic                         pkt_intercepted,
    output logic                         rsp_inserted,
    output logic [$clog2(RSP_DEPTH):0]   fifo_level,
    output logic                         fifo_full,
    output logic [CNT_W-1:0]             intercept_cnt,
    output logic [CNT_W-1:0]             response_cnt
);

    localparam int unsigned PTR_W        = $clog2(RSP_DEPTH);
    localparam int unsigned LVL_W        = PTR_W + 1;
    localparam int unsigned HDR_USED_BIT = 69;
    localparam int unsigned HDR_LEN_BIT  = 65;

    typedef enum logic [2:0] {
        MEM_NOP    = 3'd0,
        MEM_READ_1 = 3'd1,
        MEM_READ_8 = 3'd2,
        MEM_WRITE  = 3'd3,
        MEM_UPDATE = 3'd4
    } mem_op_e;

    typedef struct packed {
        logic        frm_used;
        logic        frm_owned;
        logic [1:0]  frm_priority;
        logic        frm_len;
        logic [2:0]  mem_op;
        logic [1:0]  mem_space;
        logic [7:0]  net_addr;
        logic [3:0]  frm_sid;
        logic [7:0]  frm_rid;
        logic [39:0] mem_addr;
    } rbus_hdr_t;

    rbus_hdr_t              d2r_hdr;
    rbus_hdr_t              head_hdr;
    rbus_hdr_t              rsp_hdr;
    rbus_hdr_t              fifo_mem_q [RSP_DEPTH];

    logic                   addr_hit;
    logic                   is_req;
    logic                   full_w;
    logic                   empty_w;
    logic                   icpt_hit;
    logic                   push;
    logic                   ins_hit;
    logic                   pop;
    logic [63:0]            fill_data;

    logic                   icpt_q, icpt_d;
    logic                   ins_q, ins_d;
    logic [2:0]             word_idx_q, word_idx_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [CNT_W-1:0]       icpt_cnt_q, icpt_cnt_d;
    logic [CNT_W-1:0]       rsp_cnt_q, rsp_cnt_d;
    logic                   d2r_sof_q, d2r_sof_d;
    logic [3:0]             d2r_ctrl_q, d2r_ctrl_d;
    logic [69:0]            d2r_bus_q, d2r_bus_d;
    logic                   r2d_sof_q, r2d_sof_d;
    logic [69:0]            r2d_bus_q, r2d_bus_d;

    assign d2r_hdr  = d2r_i_bus;
    assign head_hdr = fifo_mem_q[rd_ptr_q];
    assign full_w   = (level_q == LVL_W'(RSP_DEPTH));
    assign empty_w  = (level_q == '0);

    // Intercept decision on the d2r header and the response header it produces.
    always_comb begin
        addr_hit = (((d2r_hdr.mem_addr ^ ADDR_BASE) & ADDR_MASK) == '0);
        is_req   = (d2r_hdr.mem_op == MEM_READ_1) ||
                   (d2r_hdr.mem_op == MEM_READ_8) ||
                   (d2r_hdr.mem_op == MEM_UPDATE);
        icpt_hit = enable & d2r_hdr.frm_used & ~d2r_hdr.frm_owned & addr_hit & ~full_w;
        push     = d2r_i_sof & icpt_hit & is_req;

        rsp_hdr           = d2r_hdr;
        rsp_hdr.frm_used  = 1'b1;
        rsp_hdr.frm_owned = 1'b0;
        rsp_hdr.frm_len   = (d2r_hdr.mem_op == MEM_READ_8) |
                            ((d2r_hdr.mem_op == MEM_UPDATE) & d2r_hdr.frm_len);
    end

    // d2r path: latch the intercept flag at sof and blank the whole slot while set.
    always_comb begin
        d2r_sof_d  = d2r_i_sof;
        icpt_d     = d2r_i_sof ? icpt_hit : icpt_q;
        d2r_ctrl_d = d2r_i_ctrl;
        d2r_bus_d  = d2r_i_bus;
        if (icpt_d) begin
            d2r_ctrl_d = '0;
            d2r_bus_d  = '0;
        end
        icpt_cnt_d = icpt_cnt_q;
        if (d2r_i_sof && icpt_hit) begin
            icpt_cnt_d = icpt_cnt_q + CNT_W'(1);
        end
    end

    // r2d path: insert the queue head into a matching empty slot, then fill payload.
    always_comb begin
        ins_hit   = ~empty_w & ~r2d_i_bus[HDR_USED_BIT] &
                    (r2d_i_bus[HDR_LEN_BIT] == head_hdr.frm_len);
        pop       = r2d_i_sof & ins_hit;
        r2d_sof_d = r2d_i_sof;
        ins_d     = r2d_i_sof ? ins_hit : ins_q;

        word_idx_d = word_idx_q;
        if (r2d_i_sof) begin
            word_idx_d = '0;
        end else if (ins_q && (word_idx_q != 3'd7)) begin
            word_idx_d = word_idx_q + 3'd1;
        end

        fill_data = (FILL_MODE == 1) ? {FILL_DWORD[63:8], 5'b0, word_idx_q} : FILL_DWORD;

        r2d_bus_d = r2d_i_bus;
        if (r2d_i_sof) begin
            if (ins_hit) begin
                r2d_bus_d = head_hdr;
            end
        end else if (ins_q) begin
            r2d_bus_d = {6'h3F, fill_data};
        end

        rsp_cnt_d = rsp_cnt_q;
        if (pop) begin
            rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
        end
    end

    // Response FIFO pointers and level; a same-cycle pop never makes room for a push.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icpt_q     <= 1'b0;
            ins_q      <= 1'b0;
            word_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            icpt_cnt_q <= '0;
            rsp_cnt_q  <= '0;
            d2r_sof_q  <= 1'b0;
            d2r_ctrl_q <= '0;
            d2r_bus_q  <= '0;
            r2d_sof_q  <= 1'b0;
            r2d_bus_q  <= '0;
        end else begin
            icpt_q     <= icpt_d;
            ins_q      <= ins_d;
            word_idx_q <= word_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            icpt_cnt_q <= icpt_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            d2r_sof_q  <= d2r_sof_d;
            d2r_ctrl_q <= d2r_ctrl_d;
            d2r_bus_q  <= d2r_bus_d;
            r2d_sof_q  <= r2d_sof_d;
            r2d_bus_q  <= r2d_bus_d;
        end
    end

    // Response header storage; contents are only meaningful below the level.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= rsp_hdr;
        end
    end

    assign d2r_o_sof       = d2r_sof_q;
    assign d2r_o_ctrl      = d2r_ctrl_q;
    assign d2r_o_bus       = d2r_bus_q;
    assign r2d_o_sof       = r2d_sof_q;
    assign r2d_o_bus       = r2d_bus_q;
    assign pkt_intercepted = icpt_q;
    assign rsp_inserted    = ins_q;
    assign fifo_level      = level_q;
    assign fifo_full       = full_w;
    assign intercept_cnt   = icpt_cnt_q;
    assign response_cnt    = rsp_cnt_q;

endmodule
